// File: rtl/pipelined_ripple_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_ripple_adder_if
//  Description : Valid/ready operand and result streams of the pipelined adder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_ripple_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_ripple_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_ripple_adder
//  Description : WIDTH-bit add/sub as a ripple chain, one SEG_WIDTH slice per
//                pipeline stage, valid/ready streaming with full backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_ripple_adder #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    pipelined_ripple_adder_if.slave   bus
);
    localparam int NUM_STAGES = WIDTH / SEG_WIDTH;

    logic                 w_adv;
    logic [WIDTH-1:0]     w_b_eff;
    logic                 w_c0;
    logic [WIDTH-1:0]     w_in_a [NUM_STAGES];
    logic [WIDTH-1:0]     w_in_b [NUM_STAGES];
    logic [WIDTH-1:0]     w_in_s [NUM_STAGES];
    logic                 w_in_c [NUM_STAGES];
    logic [SEG_WIDTH:0]   w_sl   [NUM_STAGES];
    logic [WIDTH-1:0]     w_nx_s [NUM_STAGES];
    logic                 w_ovf_nxt;

    // Operands ride along whole (skew), partial sums accumulate (deskew).
    logic [WIDTH-1:0]     r_a [NUM_STAGES];
    logic [WIDTH-1:0]     r_b [NUM_STAGES];
    logic [WIDTH-1:0]     r_s [NUM_STAGES];
    logic                 r_c [NUM_STAGES];
    logic                 r_v [NUM_STAGES];
    logic                 r_ovf;

    assign w_adv        = !r_v[NUM_STAGES-1] || bus.out_ready;
    assign bus.in_ready = w_adv;

    always_comb begin
        w_b_eff   = bus.sub ? ~bus.b : bus.b;
        w_c0      = bus.sub ? ~bus.cin : bus.cin;
        w_in_a[0] = bus.a;
        w_in_b[0] = w_b_eff;
        w_in_s[0] = '0;
        w_in_c[0] = w_c0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            w_in_a[k] = r_a[k-1];
            w_in_b[k] = r_b[k-1];
            w_in_s[k] = r_s[k-1];
            w_in_c[k] = r_c[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_sl[k]   = {1'b0, w_in_a[k][k*SEG_WIDTH +: SEG_WIDTH]}
                      + {1'b0, w_in_b[k][k*SEG_WIDTH +: SEG_WIDTH]}
                      + {{SEG_WIDTH{1'b0}}, w_in_c[k]};
            w_nx_s[k] = w_in_s[k];
            w_nx_s[k][k*SEG_WIDTH +: SEG_WIDTH] = w_sl[k][SEG_WIDTH-1:0];
        end
        // a^b^s at the MSB recovers the carry into the MSB.
        w_ovf_nxt = w_in_a[NUM_STAGES-1][WIDTH-1] ^ w_in_b[NUM_STAGES-1][WIDTH-1]
                  ^ w_nx_s[NUM_STAGES-1][WIDTH-1] ^ w_sl[NUM_STAGES-1][SEG_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_v[0] <= bus.in_valid;
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_v[k] <= r_v[k-1];
            end
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_a[k] <= w_in_a[k];
                r_b[k] <= w_in_b[k];
                r_s[k] <= w_nx_s[k];
                r_c[k] <= w_sl[k][SEG_WIDTH];
            end
            r_ovf <= w_ovf_nxt;
        end
    end

    assign bus.out_valid = r_v[NUM_STAGES-1];
    assign bus.sum       = r_s[NUM_STAGES-1];
    assign bus.cout      = r_c[NUM_STAGES-1];
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire
